imm_fetch_ctrl: RTL and testbench

//  Sequences immediate capture for two-word instructions between fetch and decode.
//  - Word 1 is the opcode word. When the decoder flags it as needing an immediate,

---
 rtl/imm_fetch_ctrl.sv | 115 +++++++++++
 tb/tb_imm_fetch_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_fetch_ctrl.sv
// Pairs an opcode word with an optional 16-bit immediate and presents both to decode as one registered beat.
// Optional: define IMM_ZEXT_EN to add in_zext, selecting zero- instead of sign-extension per instruction.
module imm_fetch_ctrl #(
  parameter int INSTR_W = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_word,
  input  logic               in_need_imm,
`ifdef IMM_ZEXT_EN
  input  logic               in_zext,
`endif
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [DATA_W-1:0]  out_imm,
  output logic               out_has_imm,
  output logic               busy,
  output logic               timeout_err
);

  // Handshake: a word moves when in_valid && in_ready; a beat moves when out_valid && out_ready.
  // in_ready is high whenever the output register is empty or being drained this cycle.

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [0:0] {IDLE, WAIT_IMM} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [INSTR_W-1:0] op_q;
  logic [DATA_W-1:0]  imm_ext;
  logic               accept;
`ifdef IMM_ZEXT_EN
  logic               zext_q;
`endif

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == WAIT_IMM);

  always_comb begin
    imm_ext = {{(DATA_W-INSTR_W){in_word[INSTR_W-1]}}, in_word};
`ifdef IMM_ZEXT_EN
    if (zext_q) imm_ext = {{(DATA_W-INSTR_W){1'b0}}, in_word};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= '0;
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_imm     <= '0;
      out_has_imm <= 1'b0;
      timeout_err <= 1'b0;
`ifdef IMM_ZEXT_EN
      zext_q      <= 1'b0;
`endif
    end else begin
      timeout_err <= 1'b0;
      if (flush) begin
        // Anything accepted alongside a flush is discarded, including a pending opcode word.
        state     <= IDLE;
        out_valid <= 1'b0;
        cnt       <= '0;
      end else begin
        if (out_valid && out_ready) out_valid <= 1'b0;
        case (state)
          IDLE: begin
            if (accept) begin
              if (in_need_imm) begin
                op_q  <= in_word;
                cnt   <= '0;
                state <= WAIT_IMM;
`ifdef IMM_ZEXT_EN
                zext_q <= in_zext;
`endif
              end else begin
                out_valid   <= 1'b1;
                out_instr   <= in_word;
                out_imm     <= '0;
                out_has_imm <= 1'b0;
              end
            end
          end
          WAIT_IMM: begin
            if (accept) begin
              out_valid   <= 1'b1;
              out_instr   <= op_q;
              out_imm     <= imm_ext;
              out_has_imm <= 1'b1;
              state       <= IDLE;
            end else if ((TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1))) begin
              state       <= IDLE;
              cnt         <= '0;
              timeout_err <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imm_fetch_ctrl.sv
// Scoreboard bench for imm_fetch_ctrl: expected beats are queued as words are driven and checked as decode consumes them.
// Builds with or without IMM_ZEXT_EN.
module tb_imm_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_word = '0;
  logic        in_need_imm = 1'b0;
`ifdef IMM_ZEXT_EN
  logic        in_zext = 1'b0;
`endif
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_instr;
  logic [31:0] out_imm;
  logic        out_has_imm;
  logic        busy;
  logic        timeout_err;

  imm_fetch_ctrl #(.INSTR_W(16), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .in_need_imm(in_need_imm),
`ifdef IMM_ZEXT_EN
    .in_zext(in_zext),
`endif
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_imm(out_imm), .out_has_imm(out_has_imm), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Expected beat layout: {instr[15:0], imm[31:0], has_imm}
  logic [48:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_pop = 0;
  int prev_pop = 0;
  int to_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sext(input logic [15:0] w);
    return {{16{w[15]}}, w};
  endfunction

  // Monitor: mid-cycle, compare any beat that decode takes at the coming edge.
  always @(negedge clk) begin
    logic [48:0] e;
    cyc++;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {48'd0, out_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("beat_instr", {48'd0, out_instr}, {48'd0, e[48:33]});
        check("beat_imm", {32'd0, out_imm}, {32'd0, e[32:1]});
        check("beat_has_imm", {63'd0, out_has_imm}, {63'd0, e[0]});
        prev_pop = last_pop;
        last_pop = cyc;
      end
    end
    if (!rst && timeout_err) to_cnt++;
  end

  task automatic send_word(input logic [15:0] w, input logic ni);
    int n;
    in_valid = 1'b1;
    in_word = w;
    in_need_imm = ni;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_need_imm = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      n++;
      @(negedge clk);
    end
    check("drain", {32'd0, exp_q.size()}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] w;
    logic [15:0] imm;
    logic        ni;

    // Reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_imm", {32'd0, out_imm}, 64'd0);
    check("rst_has_imm", {63'd0, out_has_imm}, 64'd0);
    check("rst_timeout", {63'd0, timeout_err}, 64'd0);
    @(posedge clk);
    #1;

    // Negative immediate is sign-extended
    out_ready = 1'b1;
    exp_q.push_back({16'h1234, 32'hFFFF_8402, 1'b1});
    send_word(16'h1234, 1'b1);
    @(negedge clk);
    check("busy_wait_imm", {63'd0, busy}, 64'd1);
    @(posedge clk);
    #1;
    send_word(16'h8402, 1'b0);
    wait_drain();

    // Positive immediate
    exp_q.push_back({16'h1234, 32'h0000_4402, 1'b1});
    send_word(16'h1234, 1'b1);
    send_word(16'h4402, 1'b1);
    wait_drain();

`ifdef IMM_ZEXT_EN
    // Zero-extension flag travels with the opcode word
    exp_q.push_back({16'h1234, 32'h0000_8402, 1'b1});
    in_zext = 1'b1;
    send_word(16'h1234, 1'b1);
    in_zext = 1'b0;
    send_word(16'h8402, 1'b0);
    wait_drain();
`endif

    // Stall: beat held stable, in_ready low
    out_ready = 1'b0;
    exp_q.push_back({16'h00AB, 32'h0, 1'b0});
    send_word(16'h00AB, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", {63'd0, out_valid}, 64'd1);
      check("stall_instr", {48'd0, out_instr}, 64'h00AB);
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
    end
    @(posedge clk);
    #1;

    // Back-to-back single-word instructions
    out_ready = 1'b1;
    exp_q.push_back({16'hA000, 32'h0, 1'b0});
    exp_q.push_back({16'hA001, 32'h0, 1'b0});
    send_word(16'hA000, 1'b0);
    send_word(16'hA001, 1'b0);
    wait_drain();
    check("b2b_spacing", {32'd0, last_pop - prev_pop}, 64'd1);

    // Random mix, need_imm randomised on immediate words (must be ignored)
    for (int i = 0; i < 10; i++) begin
      w = 16'($urandom_range(0, 65535));
      ni = 1'($urandom_range(0, 1));
      if (ni) begin
        imm = 16'($urandom_range(0, 65535));
        exp_q.push_back({w, sext(imm), 1'b1});
        send_word(w, 1'b1);
        send_word(imm, 1'($urandom_range(0, 1)));
      end else begin
        exp_q.push_back({w, 32'h0, 1'b0});
        send_word(w, 1'b0);
      end
    end
    wait_drain();
    check("no_spurious_timeout", {32'd0, to_cnt}, 64'd0);

    // Timeout after 15 idle cycles in WAIT_IMM
    send_word(16'h1234, 1'b1);
    for (int i = 0; i < 15; i++) @(negedge clk);
    check("to_busy_before", {63'd0, busy}, 64'd1);
    check("to_no_pulse_early", {63'd0, timeout_err}, 64'd0);
    @(negedge clk);
    check("to_pulse", {63'd0, timeout_err}, 64'd1);
    check("to_busy_after", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("to_pulse_single", {63'd0, timeout_err}, 64'd0);
    repeat (5) @(negedge clk);
    check("to_count", {32'd0, to_cnt}, 64'd1);
    check("to_no_beat", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;

    // Flush in the cycle the immediate is accepted
    send_word(16'h1234, 1'b1);
    flush = 1'b1;
    in_valid = 1'b1;
    in_word = 16'h8402;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    check("flush_still_empty", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    exp_q.push_back({16'h0001, 32'h0, 1'b0});
    send_word(16'h0001, 1'b0);
    wait_drain();
    check("flush_no_timeout", {32'd0, to_cnt}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
